apb_slave_mem: RTL and testbench
================================

# apb_slave_mem

APB3 completer (responder) memory that sits on the APB side of the AHB-to-APB bridge and answers the bridge's PSEL/PENABLE transfers. It is the synthesizable counterpart to the bridge's APB master port and is used as the default downstream peripheral in bridge integration benches. It provides a word-addressed register array, a programmable per-transfer wait-state count, and PSLVERR for illegal accesses.

## Interface
- PADDR_SIZE, 32, APB address width
- PDATA_SIZE, 32, APB data width; only 32 is supported
- MEM_DEPTH, 256, number of 32-bit words; power of two, at least 4

- PCLK  in  1  single clock; all state is updated on the rising edge
- PRESET  in  1  reset; asynchronous, active-high
- PSEL  in  1  completer select
- PENABLE  in  1  access-phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  PADDR_SIZE  byte address
- PWDATA  in  PDATA_SIZE  write data
- wait_cfg  in  4  number of wait states to insert (0–15); sampled in the setup phase
- PREADY  out  1  transfer complete
- PRDATA  out  PDATA_SIZE  read data; valid only when PREADY = 1 on a read
- PSLVERR  out  1  error response; valid only when PREADY = 1
- err_count  out  8  saturating count of errored transfers

## Operation
- **FSM states**
  - APB_IDLE. Moves to APB_SETUP when PSEL = 1 and PENABLE = 0.
  - APB_SETUP. Latches PADDR, PWRITE, PWDATA and wait_cfg into wait_cnt.
    - Moves to APB_ACCESS next cycle when PSEL = 1 and PENABLE = 1.
    - Returns to APB_IDLE if PSEL = 0.
  - APB_ACCESS.
    - While wait_cnt ≠ 0: PREADY = 0 and wait_cnt decrements each cycle.
    - When wait_cnt = 0: PREADY = 1 and the transfer completes.
    - After completion: back-to-back transfer if PSEL = 1 and PENABLE = 0, which goes to APB_SETUP; otherwise APB_IDLE.
- **Error conditions**
  - Errors are decoded from the latched address.
  - PADDR[1:0] ≠ 0 is an error.
  - PADDR ≥ MEM_DEPTH*4 is an error.
  - An errored transfer completes with PSLVERR = 1 and PRDATA = 0. Writes are suppressed.
- **Write commit**
  - The word at PADDR[$clog2(MEM_DEPTH)+1:2] is written on the edge that ends the cycle with PREADY = 1 and PWRITE = 1, when there is no error.
- **Read data**
  - PRDATA is registered and loaded on the edge that enters the PREADY = 1 cycle.
  - PRDATA is 0 in every other cycle.
- **Protocol violations**
  - PENABLE = 1 while in APB_IDLE is ignored: no PREADY and no side effects.
  - PSEL dropping during APB_ACCESS aborts the transfer: FSM to APB_IDLE, no write, no err_count change.
- **Error counter**
  - err_count increments on each errored completion and saturates at 255.
- **Reset and held values**
  - Reset values: FSM APB_IDLE, PREADY 0, PRDATA 0, PSLVERR 0, err_count 0, wait_cnt 0, all memory words 0.
  - Reset asserted mid-transfer aborts the transfer immediately; no write occurs.
  - wait_cfg changes after the setup phase do not affect the transfer in progress.

## Timing
- With wait_cfg = N, a transfer takes N+2 cycles: 1 setup cycle, N access cycles with PREADY = 0, and 1 access cycle with PREADY = 1.
- Zero-wait throughput: one transfer every 2 cycles back-to-back.
- PREADY and PSLVERR are registered outputs. There is no combinational path from any input to any output.
- Read-after-write to the same address in the next transfer returns the new data.

## Structure
- **Shared RTL package** (alongside PDATA_SIZE):
  - `apb_state_t` enum {APB_IDLE, APB_SETUP, APB_ACCESS}
  - the error-rule constant `APB_WORD_ALIGN = 2'b00`
- **Sub-module `apb_slave_regfile`**: MEM_DEPTH × 32 array.
  - One synchronous write port; one asynchronous read port.
  - Reset clear on PRESET.
- **Top level**: FSM, wait counter, error decode and err_count.

## Test plan
- Reset, then write 0xDEADBEEF to 0x10 and read 0x10, with wait_cfg = 0 -> each transfer is 2 cycles, PRDATA = 0xDEADBEEF, PSLVERR = 0.
- wait_cfg = 3, read 0x04 after reset -> PREADY low for 3 access cycles, high on the 4th, PRDATA = 0.
- Write to 0x400 (MEM_DEPTH 256), then to 0x0A -> PSLVERR = 1 on both, err_count = 2, and reads of words 0 and 2 return 0.
- Back-to-back write 0x20 = 0x1, write 0x24 = 0x2, read 0x20, read 0x24, with wait_cfg = 0 -> 8 cycles total, reads return 1 and 2.
- PRESET pulsed during the access phase of a write to 0x30 with wait_cfg = 5 -> outputs return to 0 asynchronously, and a later read of 0x30 returns 0.
- 300 errored transfers -> err_count saturates at 255.

Source files
------------

// File: rtl/apb_slave_mem_pkg.sv
// Shared types and constants for the APB completer memory.
//   APB_PDATA_SIZE : supported APB data width
//   apb_state_t    : completer transfer phase
//   APB_WORD_ALIGN : required value of PADDR[1:0]
package apb_slave_mem_pkg;

    localparam int unsigned APB_PDATA_SIZE = 32;
    localparam int unsigned APB_WAIT_W     = 4;
    localparam int unsigned APB_ERRCNT_W   = 8;

    localparam logic [1:0] APB_WORD_ALIGN = 2'b00;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_t;

endpackage

// File: rtl/apb_slave_regfile.sv
// Word-addressed register array for the APB completer memory.
//   clk, rst : clock, asynchronous active-high reset (clears every word)
//   we       : write enable; waddr/wdata written on the rising edge
//   raddr    : asynchronous read address; rdata is the addressed word
module apb_slave_regfile
    import apb_slave_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = APB_PDATA_SIZE,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Single synchronous write port with full clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer memory with programmable wait states and PSLVERR.
//   PCLK, PRESET      : clock, asynchronous active-high reset
//   PSEL, PENABLE     : APB transfer phase controls
//   PWRITE, PADDR     : direction and byte address
//   PWDATA            : write data
//   wait_cfg          : wait states for the transfer, sampled at setup
//   PREADY            : registered transfer-complete
//   PRDATA            : registered read data, zero outside the ready cycle
//   PSLVERR           : registered error response for the ready cycle
//   err_count         : saturating count of errored completions
//
// State meaning: APB_IDLE covers idle and setup cycles (a setup is
// recognised there and captured on the closing edge), APB_SETUP is the
// first access cycle after a capture, APB_ACCESS any further access
// cycle. The ready response is registered on the edge that enters the
// completing cycle, so the zero-wait case answers straight from PADDR.
module apb_slave_mem
    import apb_slave_mem_pkg::*;
#(
    parameter int unsigned PADDR_SIZE = 32,
    parameter int unsigned PDATA_SIZE = APB_PDATA_SIZE,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    input  logic [APB_WAIT_W-1:0]   wait_cfg,
    output logic                    PREADY,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PSLVERR,
    output logic [APB_ERRCNT_W-1:0] err_count
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam logic [PADDR_SIZE-1:0] ADDR_LIMIT = PADDR_SIZE'(MEM_DEPTH * 4);

    apb_state_t                  state_q, state_d;
    logic [PADDR_SIZE-1:0]       addr_q, addr_d;
    logic                        write_q, write_d;
    logic [PDATA_SIZE-1:0]       wdata_q, wdata_d;
    logic [APB_WAIT_W-1:0]       wait_cnt, wait_d;
    logic                        ready_d, slverr_d;
    logic [PDATA_SIZE-1:0]       rdata_d;
    logic [APB_ERRCNT_W-1:0]     errcnt_d;

    logic [PADDR_SIZE-1:0]       resp_addr_c;
    logic                        resp_write_c;
    logic                        resp_err_c;
    logic                        mem_we_c;
    logic [PDATA_SIZE-1:0]       mem_rdata_c;

    function automatic logic addr_err(input logic [PADDR_SIZE-1:0] a);
        return (a[1:0] != APB_WORD_ALIGN) || (a >= ADDR_LIMIT);
    endfunction

    apb_slave_regfile #(
        .DEPTH  (MEM_DEPTH),
        .DATA_W (PDATA_SIZE),
        .AW     (AW)
    ) u_regfile (
        .clk   (PCLK),
        .rst   (PRESET),
        .we    (mem_we_c),
        .waddr (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .raddr (resp_addr_c[AW+1:2]),
        .rdata (mem_rdata_c)
    );

    // Response source: live bus during setup, captured request afterwards.
    always_comb begin
        resp_addr_c  = addr_q;
        resp_write_c = write_q;
        if (state_q == APB_IDLE) begin
            resp_addr_c  = PADDR;
            resp_write_c = PWRITE;
        end
        resp_err_c = addr_err(resp_addr_c);
    end

    // Next-state, capture, wait countdown, response and commit decode.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        wait_d   = wait_cnt;
        ready_d  = 1'b0;
        slverr_d = 1'b0;
        rdata_d  = '0;
        errcnt_d = err_count;
        mem_we_c = 1'b0;

        case (state_q)
            APB_IDLE: begin
                // PENABLE without a setup phase is ignored here.
                if (PSEL && !PENABLE) begin
                    state_d = APB_SETUP;
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    wait_d  = wait_cfg;
                    if (wait_cfg == '0) begin
                        ready_d  = 1'b1;
                        slverr_d = resp_err_c;
                        rdata_d  = (!resp_write_c && !resp_err_c) ? mem_rdata_c : '0;
                    end
                end
            end
            APB_SETUP, APB_ACCESS: begin
                if (!(PSEL && PENABLE)) begin
                    // Abort: no write, no error count.
                    state_d = APB_IDLE;
                end else if (PREADY) begin
                    state_d = APB_IDLE;
                    if (resp_err_c) begin
                        if (err_count != '1) begin
                            errcnt_d = err_count + APB_ERRCNT_W'(1);
                        end
                    end else if (write_q) begin
                        mem_we_c = 1'b1;
                    end
                end else begin
                    state_d = APB_ACCESS;
                    wait_d  = wait_cnt - APB_WAIT_W'(1);
                    if (wait_cnt == APB_WAIT_W'(1)) begin
                        ready_d  = 1'b1;
                        slverr_d = resp_err_c;
                        rdata_d  = (!resp_write_c && !resp_err_c) ? mem_rdata_c : '0;
                    end
                end
            end
            default: state_d = APB_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= APB_IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            wait_cnt  <= '0;
            PREADY    <= 1'b0;
            PRDATA    <= '0;
            PSLVERR   <= 1'b0;
            err_count <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            wait_cnt  <= wait_d;
            PREADY    <= ready_d;
            PRDATA    <= rdata_d;
            PSLVERR   <= slverr_d;
            err_count <= errcnt_d;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomized self-checking bench for apb_slave_mem against a word-array model.
module tb_apb_slave_mem;

    localparam int unsigned DEPTH = 256;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  wait_cfg;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;
    logic [7:0]  err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] model_mem [DEPTH];
    int          model_err;

    apb_slave_mem #(
        .PADDR_SIZE (32),
        .PDATA_SIZE (32),
        .MEM_DEPTH  (DEPTH)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .wait_cfg  (wait_cfg),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLVERR   (PSLVERR),
        .err_count (err_count)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic is_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
        model_err = 0;
    endtask

    task automatic do_reset();
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; wait_cfg = '0;
        model_clear();
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    task automatic go_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge PCLK);
            PSEL = 1'b0; PENABLE = 1'b0;
            check("idle_pready", 32'(PREADY), 32'd0);
        end
    endtask

    // One complete transfer; checks response, wait length and error count.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wc, output int t_setup, output int t_done);
        logic        err;
        logic [31:0] exp_rd;
        int          waits;
        @(negedge PCLK);
        check("errcnt", 32'(err_count), 32'(model_err));
        check("setup_pready", 32'(PREADY), 32'd0);
        t_setup = cyc;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; wait_cfg = wc;
        @(negedge PCLK);
        PENABLE  = 1'b1;
        wait_cfg = 4'($urandom);
        waits = 0;
        while (PREADY !== 1'b1 && waits < 20) begin
            check("wait_prdata", PRDATA, 32'd0);
            @(negedge PCLK);
            waits++;
        end
        t_done = cyc;
        err    = is_err(addr);
        exp_rd = (!wr && !err) ? model_mem[addr[9:2]] : 32'd0;
        check("pready", 32'(PREADY), 32'd1);
        check("waits", 32'(waits), 32'(wc));
        check("pslverr", 32'(PSLVERR), 32'(err));
        check("prdata", PRDATA, exp_rd);
        if (err) begin
            if (model_err < 255) model_err++;
        end else if (wr) begin
            model_mem[addr[9:2]] = wdata;
        end
    endtask

    // Transfer that drops PSEL during the wait states.
    task automatic xfer_abort(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wc);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; wait_cfg = wc;
        @(negedge PCLK);
        PENABLE = 1'b1;
        check("abort_pready", 32'(PREADY), 32'd0);
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
        if (sel == 1) return 32'(DEPTH * 4) + 32'($urandom_range(0, 4096));
        if (sel < 6)  return {28'd0, 4'($urandom), 2'b00};
        return {22'd0, 8'($urandom), 2'b00};
    endfunction

    initial begin
        int          ts, td, t0;
        logic [31:0] a;
        do_reset();

        @(negedge PCLK);
        check("rst_pready", 32'(PREADY), 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        check("rst_errcnt", 32'(err_count), 32'd0);

        // Zero-wait write then read.
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'd0, ts, td);
        check("wr_cycles", 32'(td - ts + 1), 32'd2);
        xfer(1'b0, 32'h10, 32'd0, 4'd0, ts, td);
        check("rd_cycles", 32'(td - ts + 1), 32'd2);
        check("rd_deadbeef", PRDATA, 32'hDEADBEEF);
        go_idle(1);

        // Three wait states on a never-written word.
        xfer(1'b0, 32'h04, 32'd0, 4'd3, ts, td);
        check("w3_cycles", 32'(td - ts + 1), 32'd5);
        go_idle(1);

        // Out-of-range and misaligned writes are suppressed.
        xfer(1'b1, 32'h400, 32'h11111111, 4'd0, ts, td);
        xfer(1'b1, 32'h0A, 32'h22222222, 4'd1, ts, td);
        xfer(1'b0, 32'h00, 32'd0, 4'd0, ts, td);
        xfer(1'b0, 32'h08, 32'd0, 4'd0, ts, td);
        check("errcnt_two", 32'(err_count), 32'd2);
        go_idle(1);

        // Four back-to-back zero-wait transfers.
        xfer(1'b1, 32'h20, 32'h1, 4'd0, t0, td);
        xfer(1'b1, 32'h24, 32'h2, 4'd0, ts, td);
        xfer(1'b0, 32'h20, 32'd0, 4'd0, ts, td);
        check("b2b_rd20", PRDATA, 32'h1);
        xfer(1'b0, 32'h24, 32'd0, 4'd0, ts, td);
        check("b2b_rd24", PRDATA, 32'h2);
        check("b2b_cycles", 32'(td - t0 + 1), 32'd8);
        go_idle(1);

        // PENABLE without a setup phase is ignored.
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h40; PWDATA = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check("noset_pready", 32'(PREADY), 32'd0);
        end
        go_idle(1);
        xfer(1'b0, 32'h40, 32'd0, 4'd0, ts, td);
        go_idle(1);

        // Aborted write and aborted errored transfer leave no trace.
        xfer_abort(1'b1, 32'h44, 32'h12345678, 4'd2);
        xfer_abort(1'b1, 32'h401, 32'h0, 4'd3);
        xfer(1'b0, 32'h44, 32'd0, 4'd0, ts, td);
        go_idle(1);

        // Reset asserted during the wait states of a write.
        xfer(1'b1, 32'h30, 32'h55AA55AA, 4'd0, ts, td);
        go_idle(1);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h30; PWDATA = 32'hCAFEF00D; wait_cfg = 4'd5;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        check("pre_rst_errcnt", 32'(err_count), 32'(model_err));
        #2 PRESET = 1'b1;
        #1;
        check("arst_errcnt", 32'(err_count), 32'd0);
        check("arst_pready", 32'(PREADY), 32'd0);
        check("arst_prdata", PRDATA, 32'd0);
        check("arst_pslverr", 32'(PSLVERR), 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        model_clear();
        @(negedge PCLK);
        PRESET = 1'b0;
        xfer(1'b0, 32'h30, 32'd0, 4'd0, ts, td);
        go_idle(1);

        // Random traffic with idle gaps and occasional aborts.
        for (int n = 0; n < 250; n++) begin
            a = rand_addr();
            if ($urandom_range(0, 15) == 0) begin
                xfer_abort(1'($urandom), a, $urandom, 4'($urandom_range(1, 4)));
            end else begin
                xfer(1'($urandom), a, $urandom, 4'($urandom_range(0, 3)), ts, td);
            end
            if ($urandom_range(0, 2) == 0) go_idle($urandom_range(1, 2));
        end
        go_idle(1);

        // Saturation of the error counter.
        for (int n = 0; n < 300; n++) begin
            xfer(1'($urandom), 32'h800 + 32'(n), 32'd0, 4'd0, ts, td);
        end
        go_idle(1);
        check("errcnt_sat", 32'(err_count), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
